pc_unit: RTL

Parametrised program-counter unit: the successor to the plain enabled PC register. It adds sequential increment, absolute jump, relative branch, and call/return through an internal circular return-address stack (RAS) with sticky error flags. It sits at the head of the fetch stage, drives the fetch address, and is steered by the decode/branch logic through a one-hot-free op code.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_unit_ras_stack.sv | 68 ++++++
 rtl/pc_unit.sv | 79 +++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared op-code type for the program-counter unit and its callers.
package pc_pkg;

    // Operation requested of the PC unit; codes 6 and 7 are reserved and act as HOLD.
    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_SEQ    = 3'd1,
        OP_JUMP   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } pc_op_t;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack with overwrite-on-full and sticky error flags.
module ras_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;   // next slot to write; the top entry sits just below it
    logic [PW:0]      count_q;
    logic             ovf_q;
    logic             unf_q;

    assign top   = mem_q[wptr_q - PTR_ONE];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    // Entry storage: written on push; when full the write slot is the oldest entry.
    // NOTE: the array has no reset; stale entries are unreachable because count_q gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wptr_q] <= din;
        end
    end

    // Pointer, occupancy and sticky flags; reset wins over push/pop.
    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (push) begin
            wptr_q <= wptr_q + PTR_ONE;
            if (full) begin
                ovf_q <= 1'b1;
            end else begin
                count_q <= count_q + CNT_ONE;
            end
        end else if (pop) begin
            if (empty) begin
                unf_q <= 1'b1;
            end else begin
                wptr_q  <= wptr_q - PTR_ONE;
                count_q <= count_q - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter: sequential step, jump, relative branch, call/return via ras_stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter logic [WIDTH-1:0] STEP      = WIDTH'(1),
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  pc_op_t           op,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] ras_top;
    logic             push;
    logic             pop;

    assign pc_seq = pc_q + STEP;
    assign push   = en && (op == OP_CALL);
    assign pop    = en && (op == OP_RET);

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_seq),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    // Next-PC mux; enable gating and reset are folded in so pc_next is exactly what loads.
    // NOTE: pc_d gets a default first so no path through this block can infer a latch.
    always_comb begin
        pc_d = pc_q;
        unique case (op)
            OP_SEQ:    pc_d = pc_seq;
            OP_JUMP:   pc_d = target;
            OP_BRANCH: pc_d = pc_q + offset;
            OP_CALL:   pc_d = target;
            OP_RET:    pc_d = ras_empty ? pc_seq : ras_top;
            default:   pc_d = pc_q;
        endcase
        if (!en) begin
            pc_d = pc_q;
        end
        if (reset) begin
            pc_d = INIT;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;

endmodule
